// File: rtl/tx_retry_ctrl_pkg.sv
// Shared constants for the xpu transmit retry controller: FSM encoding,
// completion status codes and the contention-window exponent width.
package tx_retry_ctrl_pkg;

  localparam int CW_W = 4;

  localparam logic [2:0] S_IDLE         = 3'd0;
  localparam logic [2:0] S_WAIT_BACKOFF = 3'd1;
  localparam logic [2:0] S_TX_ON        = 3'd2;
  localparam logic [2:0] S_WAIT_ACK     = 3'd3;
  localparam logic [2:0] S_REPORT       = 3'd4;

  localparam logic [1:0] ST_ACKED      = 2'b00;
  localparam logic [1:0] ST_NOACK      = 2'b01;
  localparam logic [1:0] ST_RETRY_FAIL = 2'b10;
  localparam logic [1:0] ST_ABORTED    = 2'b11;

endpackage

// File: rtl/tx_retry_ctrl_if.sv
// Request/PHY/backoff handshake bundle between the xpu transmit path and
// tx_retry_ctrl. The controller uses the slave view, its environment the master view.
interface tx_retry_ctrl_if #(
  parameter int RETRY_WIDTH  = 4,
  parameter int ACK_TO_WIDTH = 9
);
  import tx_retry_ctrl_pkg::*;

  logic                    tsf_pulse_1M;
  logic                    tx_req;
  logic                    tx_need_ack;
  logic [RETRY_WIDTH-1:0]  tx_max_retry;
  logic                    tx_abort;
  logic [CW_W-1:0]         cw_min;
  logic [CW_W-1:0]         cw_max;
  logic [ACK_TO_WIDTH-1:0] ack_timeout_time;
  logic                    backoff_done;
  logic                    phy_tx_done;
  logic                    ack_rx_strobe;

  logic                    tx_start;
  logic [CW_W-1:0]         cw_exp;
  logic [RETRY_WIDTH-1:0]  retry_count;
  logic                    tx_retry_flag;
  logic                    busy;
  logic                    tx_done;
  logic [1:0]              tx_status;

  modport slave (
    input  tsf_pulse_1M, tx_req, tx_need_ack, tx_max_retry, tx_abort,
           cw_min, cw_max, ack_timeout_time, backoff_done, phy_tx_done, ack_rx_strobe,
    output tx_start, cw_exp, retry_count, tx_retry_flag, busy, tx_done, tx_status
  );

  modport master (
    output tsf_pulse_1M, tx_req, tx_need_ack, tx_max_retry, tx_abort,
           cw_min, cw_max, ack_timeout_time, backoff_done, phy_tx_done, ack_rx_strobe,
    input  tx_start, cw_exp, retry_count, tx_retry_flag, busy, tx_done, tx_status
  );

endinterface

// File: rtl/tx_retry_ctrl_us_down_timer.sv
// Microsecond down-counter: loadable, steps down on each 1 us tick and
// parks at zero; zero_o flags expiry.
module us_down_timer #(
  parameter int ACK_TO_WIDTH = 9
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_i,
  input  logic [ACK_TO_WIDTH-1:0] load_val_i,
  input  logic                    dec_i,
  output logic                    zero_o
);

  logic [ACK_TO_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (dec_i && (cnt_q != '0))
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/tx_retry_ctrl.sv
// Transmit retry controller: waits for backoff, fires the PHY, runs the ACK
// timeout and retransmits with a growing contention window until done.
module tx_retry_ctrl
  import tx_retry_ctrl_pkg::*;
#(
  parameter int RETRY_WIDTH  = 4,
  parameter int ACK_TO_WIDTH = 9
) (
  input logic              clk,
  input logic              rst,
  tx_retry_ctrl_if.slave   bus_if
);

  logic [2:0]             state_q, state_d;
  logic                   need_ack_q, need_ack_d;
  logic [RETRY_WIDTH-1:0] max_retry_q, max_retry_d;
  logic [RETRY_WIDTH-1:0] retry_q, retry_d;
  logic                   abort_pend_q, abort_pend_d;
  logic [CW_W-1:0]        cw_q, cw_d;
  logic                   retry_flag_q, retry_flag_d;
  logic                   busy_q, busy_d;
  logic                   tx_start_q, tx_start_d;
  logic                   tx_done_q, tx_done_d;
  logic [1:0]             status_q, status_d;
  logic                   tmr_load;
  logic                   tmr_dec;
  logic                   tmr_zero;

  function automatic logic [CW_W-1:0] cw_min_of(input logic [CW_W-1:0] a,
                                                input logic [CW_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  // Widened by one bit so an exponent of 15 cannot wrap before the ceiling compare.
  function automatic logic [CW_W-1:0] cw_inc_sat(input logic [CW_W-1:0] cw,
                                                 input logic [CW_W-1:0] cw_ceil);
    logic [CW_W:0] inc;
    inc = {1'b0, cw} + 1'b1;
    return (inc > {1'b0, cw_ceil}) ? cw_ceil : inc[CW_W-1:0];
  endfunction

  us_down_timer #(.ACK_TO_WIDTH(ACK_TO_WIDTH)) u_ack_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (bus_if.ack_timeout_time),
    .dec_i      (tmr_dec),
    .zero_o     (tmr_zero)
  );

  assign tmr_dec = (state_q == S_WAIT_ACK) && bus_if.tsf_pulse_1M;

  always_comb begin
    state_d      = state_q;
    need_ack_d   = need_ack_q;
    max_retry_d  = max_retry_q;
    retry_d      = retry_q;
    abort_pend_d = abort_pend_q;
    cw_d         = cw_q;
    retry_flag_d = retry_flag_q;
    busy_d       = busy_q;
    status_d     = status_q;
    tx_start_d   = 1'b0;
    tx_done_d    = 1'b0;
    tmr_load     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus_if.tx_req) begin
          need_ack_d   = bus_if.tx_need_ack;
          max_retry_d  = bus_if.tx_max_retry;
          retry_d      = '0;
          abort_pend_d = 1'b0;
          cw_d         = cw_min_of(bus_if.cw_min, bus_if.cw_max);
          busy_d       = 1'b1;
          state_d      = S_WAIT_BACKOFF;
        end
      end
      S_WAIT_BACKOFF: begin
        if (bus_if.tx_abort) begin
          status_d  = ST_ABORTED;
          tx_done_d = 1'b1;
          state_d   = S_REPORT;
        end else if (bus_if.backoff_done) begin
          tx_start_d = 1'b1;
          state_d    = S_TX_ON;
        end
      end
      S_TX_ON: begin
        // The PHY cannot be stopped mid-frame, so an abort waits for its end.
        if (bus_if.tx_abort) abort_pend_d = 1'b1;
        if (bus_if.phy_tx_done) begin
          if (abort_pend_q || bus_if.tx_abort) begin
            status_d  = ST_ABORTED;
            tx_done_d = 1'b1;
            state_d   = S_REPORT;
          end else if (!need_ack_q) begin
            status_d  = ST_NOACK;
            tx_done_d = 1'b1;
            state_d   = S_REPORT;
          end else begin
            tmr_load = 1'b1;
            state_d  = S_WAIT_ACK;
          end
        end
      end
      S_WAIT_ACK: begin
        if (bus_if.ack_rx_strobe) begin
          status_d  = ST_ACKED;
          tx_done_d = 1'b1;
          state_d   = S_REPORT;
        end else if (bus_if.tx_abort) begin
          status_d  = ST_ABORTED;
          tx_done_d = 1'b1;
          state_d   = S_REPORT;
        end else if (tmr_zero && (retry_q == max_retry_q)) begin
          status_d  = ST_RETRY_FAIL;
          tx_done_d = 1'b1;
          state_d   = S_REPORT;
        end else if (tmr_zero) begin
          retry_d      = retry_q + 1'b1;
          cw_d         = cw_inc_sat(cw_q, bus_if.cw_max);
          retry_flag_d = 1'b1;
          state_d      = S_WAIT_BACKOFF;
        end
      end
      S_REPORT: begin
        busy_d       = 1'b0;
        retry_flag_d = 1'b0;
        cw_d         = bus_if.cw_min;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      need_ack_q   <= 1'b0;
      max_retry_q  <= '0;
      retry_q      <= '0;
      abort_pend_q <= 1'b0;
      cw_q         <= '0;
      retry_flag_q <= 1'b0;
      busy_q       <= 1'b0;
      tx_start_q   <= 1'b0;
      tx_done_q    <= 1'b0;
      status_q     <= '0;
    end else begin
      state_q      <= state_d;
      need_ack_q   <= need_ack_d;
      max_retry_q  <= max_retry_d;
      retry_q      <= retry_d;
      abort_pend_q <= abort_pend_d;
      cw_q         <= cw_d;
      retry_flag_q <= retry_flag_d;
      busy_q       <= busy_d;
      tx_start_q   <= tx_start_d;
      tx_done_q    <= tx_done_d;
      status_q     <= status_d;
    end
  end

  assign bus_if.tx_start      = tx_start_q;
  assign bus_if.cw_exp        = cw_q;
  assign bus_if.retry_count   = retry_q;
  assign bus_if.tx_retry_flag = retry_flag_q;
  assign bus_if.busy          = busy_q;
  assign bus_if.tx_done       = tx_done_q;
  assign bus_if.tx_status     = status_q;

endmodule

// File: tb/tb_tx_retry_ctrl.sv
// Scenario bench for tx_retry_ctrl: expected completions are queued at request
// time and matched against each tx_done by a negedge monitor.
module tb_tx_retry_ctrl;

  localparam int RW = 4;
  localparam int AW = 9;

  typedef struct {
    logic [1:0]    status;
    logic [RW-1:0] retry;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tx_retry_ctrl_if #(.RETRY_WIDTH(RW), .ACK_TO_WIDTH(AW)) bus ();

  tx_retry_ctrl #(.RETRY_WIDTH(RW), .ACK_TO_WIDTH(AW)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_if (bus)
  );

  int checks = 0;
  int failures = 0;
  int start_cnt = 0;
  int done_cnt = 0;
  int tick_cnt = 0;
  int tsf_div = 0;
  exp_t exp_q[$];
  logic [3:0] cw_log[$];
  logic flag_log[$];

  // 1 us tick every 4 clocks
  initial begin
    bus.tsf_pulse_1M = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (tsf_div == 3) begin
        bus.tsf_pulse_1M = 1'b1;
        tsf_div = 0;
        tick_cnt++;
      end else begin
        bus.tsf_pulse_1M = 1'b0;
        tsf_div++;
      end
    end
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    exp_t e;
    if (bus.tx_start === 1'b1) begin
      start_cnt++;
      cw_log.push_back(bus.cw_exp);
      flag_log.push_back(bus.tx_retry_flag);
    end
    if (bus.tx_done === 1'b1) begin
      done_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_tx_done: got status=%b retry=%0d, required no completion",
                 bus.tx_status, bus.retry_count);
      end else begin
        e = exp_q.pop_front();
        if (bus.tx_status !== e.status || bus.retry_count !== e.retry) begin
          failures++;
          $display("FAIL completion: got status=%b retry=%0d, required status=%b retry=%0d",
                   bus.tx_status, bus.retry_count, e.status, e.retry);
        end
      end
      checks++;
      if (bus.busy !== 1'b1) begin
        failures++;
        $display("FAIL busy_during_done: got %b required 1", bus.busy);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic push_exp(input logic [1:0] st, input logic [RW-1:0] rc);
    exp_t e;
    e.status = st;
    e.retry  = rc;
    exp_q.push_back(e);
  endtask

  task automatic issue_req(input logic need_ack, input logic [RW-1:0] max_r);
    bus.tx_need_ack  = need_ack;
    bus.tx_max_retry = max_r;
    bus.tx_req       = 1'b1;
    step();
    bus.tx_req       = 1'b0;
  endtask

  task automatic run_backoff(output bit ok);
    ok = 1'b0;
    bus.backoff_done = 1'b1;
    for (int i = 0; i < 300 && !ok; i++) begin
      step();
      if (bus.tx_start === 1'b1) ok = 1'b1;
    end
    bus.backoff_done = 1'b0;
  endtask

  task automatic pulse_phy();
    bus.phy_tx_done = 1'b1;
    step();
    bus.phy_tx_done = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      if (done_cnt != d0) ok = 1'b1;
      else step();
    end
    if (done_cnt != d0) ok = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if ({bus.busy, bus.tx_start, bus.tx_done, bus.tx_retry_flag} !== 4'b0000) begin
      failures++;
      $display("FAIL %s_flags: got busy/start/done/retry=%b required 0000", tag,
               {bus.busy, bus.tx_start, bus.tx_done, bus.tx_retry_flag});
    end
    checks++;
    if (bus.tx_status !== 2'b00 || bus.retry_count !== 4'd0 || bus.cw_exp !== 4'd0) begin
      failures++;
      $display("FAIL %s_values: got status=%b retry=%0d cw=%0d required 0/0/0", tag,
               bus.tx_status, bus.retry_count, bus.cw_exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    check_all_zero("reset");
    rst = 1'b0;
    step();
  endtask

  task automatic test_no_ack();
    bit ok;
    int s0, d0;
    bus.cw_min = 4'd3; bus.cw_max = 4'd7;
    s0 = start_cnt; d0 = done_cnt;
    push_exp(2'b01, 4'd0);
    issue_req(1'b0, 4'd2);
    checks++;
    if (bus.busy !== 1'b1) begin failures++; $display("FAIL noack_busy_rise: got %b required 1", bus.busy); end
    repeat (4) step();
    run_backoff(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL noack_tx_start: got none required 1 pulse"); end
    checks++;
    if (bus.cw_exp !== 4'd3) begin failures++; $display("FAIL noack_cw: got %0d required 3", bus.cw_exp); end
    repeat (3) step();
    pulse_phy();
    wait_done(d0, 50, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL noack_done_timeout: got no tx_done required 1"); end
    checks++;
    if (start_cnt - s0 != 1) begin failures++; $display("FAIL noack_starts: got %0d required 1", start_cnt - s0); end
    checks++;
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL noack_busy_fall: got %b required 0", bus.busy); end
  endtask

  task automatic test_ack_rx();
    bit ok;
    int s0, d0, t0, cw_bad;
    bus.cw_min = 4'd2; bus.cw_max = 4'd5; bus.ack_timeout_time = 9'd44;
    s0 = start_cnt; d0 = done_cnt; cw_bad = 0;
    push_exp(2'b00, 4'd0);
    issue_req(1'b1, 4'd3);
    run_backoff(ok);
    pulse_phy();
    t0 = tick_cnt;
    for (int i = 0; i < 400 && tick_cnt < t0 + 30; i++) begin
      if (bus.cw_exp !== 4'd2 || bus.tx_retry_flag !== 1'b0) cw_bad++;
      step();
    end
    bus.ack_rx_strobe = 1'b1;
    step();
    bus.ack_rx_strobe = 1'b0;
    wait_done(d0, 50, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL ack_done_timeout: got no tx_done required 1"); end
    checks++;
    if (start_cnt - s0 != 1) begin failures++; $display("FAIL ack_starts: got %0d required 1", start_cnt - s0); end
    checks++;
    if (cw_bad != 0) begin failures++; $display("FAIL ack_cw_stable: got %0d bad cycles required 0", cw_bad); end
  endtask

  task automatic test_retries_exhausted();
    bit ok, all_ok;
    int s0, d0, c0;
    logic [3:0] exp_cw[4];
    logic       exp_fl[4];
    exp_cw = '{4'd4, 4'd5, 4'd6, 4'd6};
    exp_fl = '{1'b0, 1'b1, 1'b1, 1'b1};
    bus.cw_min = 4'd4; bus.cw_max = 4'd6; bus.ack_timeout_time = 9'd3;
    s0 = start_cnt; d0 = done_cnt; c0 = cw_log.size(); all_ok = 1'b1;
    push_exp(2'b10, 4'd3);
    issue_req(1'b1, 4'd3);
    for (int a = 0; a < 4; a++) begin
      run_backoff(ok);
      all_ok &= ok;
      repeat (2) step();
      pulse_phy();
    end
    wait_done(d0, 300, ok);
    checks++;
    if (!(ok && all_ok)) begin failures++; $display("FAIL retry_progress: got done=%b starts_ok=%b required 1/1", ok, all_ok); end
    checks++;
    if (start_cnt - s0 != 4) begin failures++; $display("FAIL retry_starts: got %0d required 4", start_cnt - s0); end
    if (cw_log.size() >= c0 + 4) begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (cw_log[c0+i] !== exp_cw[i] || flag_log[c0+i] !== exp_fl[i]) begin
          failures++;
          $display("FAIL retry_attempt%0d: got cw=%0d flag=%b required cw=%0d flag=%b",
                   i, cw_log[c0+i], flag_log[c0+i], exp_cw[i], exp_fl[i]);
        end
      end
    end
    checks++;
    if (bus.retry_count !== 4'd3 || bus.cw_exp !== 4'd4 || bus.tx_retry_flag !== 1'b0) begin
      failures++;
      $display("FAIL retry_after_report: got retry=%0d cw=%0d flag=%b required 3/4/0",
               bus.retry_count, bus.cw_exp, bus.tx_retry_flag);
    end
  endtask

  task automatic test_simultaneous();
    bit ok;
    int s0, d0;
    bus.cw_min = 4'd1; bus.cw_max = 4'd3; bus.ack_timeout_time = 9'd0;
    d0 = done_cnt;
    push_exp(2'b00, 4'd0);
    issue_req(1'b1, 4'd0);
    run_backoff(ok);
    bus.phy_tx_done = 1'b1;
    step();
    bus.phy_tx_done = 1'b0;
    bus.ack_rx_strobe = 1'b1;
    step();
    bus.ack_rx_strobe = 1'b0;
    wait_done(d0, 20, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL simul_done_timeout: got no tx_done required 1"); end
    // Zero timeout with no ACK and a single allowed attempt
    s0 = start_cnt; d0 = done_cnt;
    push_exp(2'b10, 4'd0);
    issue_req(1'b1, 4'd0);
    run_backoff(ok);
    pulse_phy();
    wait_done(d0, 20, ok);
    checks++;
    if (!ok || start_cnt - s0 != 1) begin
      failures++;
      $display("FAIL zero_timeout: got done=%b starts=%0d required 1/1", ok, start_cnt - s0);
    end
  endtask

  task automatic test_abort();
    bit ok;
    int s0, d0;
    bus.cw_min = 4'd2; bus.cw_max = 4'd4; bus.ack_timeout_time = 9'd10;
    d0 = done_cnt;
    push_exp(2'b11, 4'd0);
    issue_req(1'b1, 4'd2);
    run_backoff(ok);
    bus.tx_abort = 1'b1;
    step();
    bus.tx_abort = 1'b0;
    repeat (5) step();
    checks++;
    if (done_cnt != d0 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL abort_txon_early: got dones=%0d busy=%b required 0/1", done_cnt - d0, bus.busy);
    end
    pulse_phy();
    wait_done(d0, 20, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL abort_txon_done: got no tx_done required 1"); end
    // Abort and backoff_done together in WAIT_BACKOFF
    s0 = start_cnt; d0 = done_cnt;
    push_exp(2'b11, 4'd0);
    issue_req(1'b0, 4'd0);
    bus.backoff_done = 1'b1;
    bus.tx_abort = 1'b1;
    step();
    bus.backoff_done = 1'b0;
    bus.tx_abort = 1'b0;
    wait_done(d0, 20, ok);
    checks++;
    if (!ok || start_cnt != s0) begin
      failures++;
      $display("FAIL abort_backoff: got done=%b starts=%0d required 1/0", ok, start_cnt - s0);
    end
    // Abort while waiting for the ACK
    d0 = done_cnt;
    push_exp(2'b11, 4'd0);
    issue_req(1'b1, 4'd2);
    run_backoff(ok);
    pulse_phy();
    repeat (2) step();
    bus.tx_abort = 1'b1;
    step();
    bus.tx_abort = 1'b0;
    wait_done(d0, 20, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL abort_waitack: got no tx_done required 1"); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int d0;
    bus.cw_min = 4'd3; bus.cw_max = 4'd5; bus.ack_timeout_time = 9'd40;
    issue_req(1'b1, 4'd2);
    run_backoff(ok);
    pulse_phy();
    repeat (3) step();
    checks++;
    if (bus.busy !== 1'b1 || bus.cw_exp !== 4'd3) begin
      failures++;
      $display("FAIL rstmid_pre: got busy=%b cw=%0d required 1/3", bus.busy, bus.cw_exp);
    end
    rst = 1'b1;
    step();
    check_all_zero("rstmid");
    rst = 1'b0;
    d0 = done_cnt;
    repeat (100) step();
    checks++;
    if (done_cnt != d0) begin failures++; $display("FAIL rstmid_no_done: got %0d dones required 0", done_cnt - d0); end
    d0 = done_cnt;
    push_exp(2'b01, 4'd0);
    issue_req(1'b0, 4'd1);
    run_backoff(ok);
    pulse_phy();
    wait_done(d0, 50, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL rstmid_recover: got no tx_done required 1"); end
  endtask

  initial begin
    rst = 1'b1;
    bus.tx_req = 1'b0; bus.tx_need_ack = 1'b0; bus.tx_max_retry = '0;
    bus.tx_abort = 1'b0; bus.cw_min = 4'd0; bus.cw_max = 4'd0;
    bus.ack_timeout_time = '0; bus.backoff_done = 1'b0;
    bus.phy_tx_done = 1'b0; bus.ack_rx_strobe = 1'b0;
    test_reset();
    test_no_ack();
    test_ack_rx();
    test_retries_exhausted();
    test_simultaneous();
    test_abort();
    test_reset_mid();
    repeat (3) step();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL missing_completions: got %0d outstanding required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
